// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle MIPS-subset core.
// Holds opcode/funct values, the control FSM state type and the ALU operation type.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam int REG_AW = 5;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    typedef struct packed {
        logic    valid;
        alu_op_e op;
    } alu_dec_t;

    // Unsupported funct codes come back with valid=0 and retire as a NOP.
    function automatic alu_dec_t decode_funct(input logic [5:0] funct);
        alu_dec_t d;
        d.valid = 1'b1;
        d.op    = ALU_ADD;
        case (funct)
            FN_ADD:  d.op = ALU_ADD;
            FN_SUB:  d.op = ALU_SUB;
            FN_AND:  d.op = ALU_AND;
            FN_OR:   d.op = ALU_OR;
            FN_SLT:  d.op = ALU_SLT;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: NREG x XLEN register file, two async read ports, one sync write port.
// r0 always reads zero and writes to it are dropped.
module mc_regfile
    import mc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [XLEN-1:0]   wd
);

    logic [XLEN-1:0] regs_q [NREG];

    // NOTE: the array is cleared by reset because every register must read 0 after reset;
    // a register file without that guarantee could be left unreset and mapped to RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we && (wa != '0)) begin
            regs_q[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle MIPS-subset core; fetch and data share one req/ready memory port.
// Define PERF_CNT_EN to build the cycle and retired-instruction counters (tied to 0 otherwise).
module mc_datapath
    import mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            halted,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instret_cnt
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d;
    logic [XLEN-1:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
    logic [31:0]     ir_q, ir_d;
    logic            halted_q, halted_d;

    logic [5:0]        opcode, funct;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [XLEN-1:0]   sext_imm, addr_raw;
    logic [XLEN-1:0]   rf_rd1, rf_rd2, rf_wd;
    logic [REG_AW-1:0] rf_wa;
    logic              rf_we, mem_xfer;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign sext_imm = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};

    mc_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs),
        .ra2 (rt),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (rf_we),
        .wa  (rf_wa),
        .wd  (rf_wd)
    );

    alu_dec_t        alu_dec;
    alu_op_e         alu_op;
    logic [XLEN-1:0] alu_b, alu_y;

    always_comb begin
        alu_dec = decode_funct(funct);
        alu_op  = (opcode == OP_RTYPE) ? alu_dec.op : ALU_ADD;
        alu_b   = (opcode == OP_RTYPE) ? b_q : sext_imm;
        case (alu_op)
            ALU_ADD: alu_y = a_q + alu_b;
            ALU_SUB: alu_y = a_q - alu_b;
            ALU_AND: alu_y = a_q & alu_b;
            ALU_OR:  alu_y = a_q | alu_b;
            ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
            default: alu_y = '0;
        endcase
    end

    // Requests are decoded from the state and forced low while reset is asserted,
    // so a reset mid-transaction withdraws the request in the same cycle.
    assign mem_req   = rst && ((state_q == S_FETCH) || (state_q == S_MEM));
    assign mem_we    = rst && (state_q == S_MEM) && (opcode == OP_SW);
    assign addr_raw  = (state_q == S_MEM) ? alu_out_q : pc_q;
    assign mem_addr  = {addr_raw[XLEN-1:2], 2'b00};
    assign mem_wdata = b_q;
    assign mem_xfer  = mem_req && mem_ready;
    assign halted    = halted_q;
    assign pc        = pc_q;

    always_comb begin
        // NOTE: every value assigned here gets a default first, so no path infers a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        halted_d  = halted_q;
        rf_we     = 1'b0;
        rf_wa     = rt;
        rf_wd     = alu_out_q;
        case (state_q)
            S_FETCH: if (mem_xfer) begin
                ir_d    = mem_rdata[31:0];
                pc_d    = pc_q + PC_STEP;
                state_d = S_DECODE;
            end
            S_DECODE: if (ir_q == '0) begin
                state_d  = S_HALT;
                halted_d = 1'b1;
            end else begin
                a_d       = rf_rd1;
                b_d       = rf_rd2;
                alu_out_d = pc_q + (sext_imm << 2);
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_RTYPE: if (alu_dec.valid) begin
                        alu_out_d = alu_y;
                        state_d   = S_WB;
                    end
                    OP_ADDI: begin
                        alu_out_d = alu_y;
                        state_d   = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_out_d = alu_y;
                        state_d   = S_MEM;
                    end
                    OP_BEQ: if (a_q == b_q) pc_d = alu_out_q;
                    OP_BNE: if (a_q != b_q) pc_d = alu_out_q;
                    OP_J:   pc_d = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
                    default: ;
                endcase
            end
            S_MEM: if (mem_xfer) begin
                if (opcode == OP_LW) begin
                    mdr_d   = mem_rdata;
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_RTYPE: begin
                        rf_we = 1'b1;
                        rf_wa = rd;
                    end
                    OP_ADDI: rf_we = 1'b1;
                    OP_LW: begin
                        rf_we = 1'b1;
                        rf_wd = mdr_q;
                    end
                    default: ;
                endcase
            end
            S_HALT:  ;
            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
            halted_q  <= halted_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;
    logic        retire;

    // Only EXEC, MEM and WB can move into FETCH, so this marks exactly one retirement.
    assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + 32'd1;
        instret_cnt_d = instret_cnt_q + {31'd0, retire};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed-program bench for mc_datapath with a wait-state memory model.
// Counter expectations follow whether PERF_CNT_EN is defined for the build.
module tb_mc_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    mc_datapath #(.XLEN(32), .NREG(32), .RESET_PC(32'h0)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .halted      (halted),
        .pc          (pc),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Memory model: ready after wait_cycles stalled cycles of a request.
    logic [31:0] mem [128];
    int          wait_cycles = 0;
    int          wcnt;

    assign mem_ready = mem_req && (wcnt >= wait_cycles);
    assign mem_rdata = mem[mem_addr[8:2]];

    always @(posedge clk or negedge rst) begin
        if (!rst) wcnt <= 0;
        else if (mem_req) wcnt <= mem_ready ? 0 : wcnt + 1;
    end

    always @(posedge clk) begin
        if (rst && mem_req && mem_ready && mem_we) mem[mem_addr[8:2]] = mem_wdata;
    end

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          cycles;
    } xfer_t;

    xfer_t       log_q[$];
    int          n_asserts = 0;
    int          n_fail    = 0;
    int          stable_err, cur_cycles;
    bit          pend;
    logic [31:0] p_addr, p_wd;
    logic        p_we;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    task automatic hold_reset();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        log_q.delete();
        stable_err = 0;
        pend       = 1'b0;
        cur_cycles = 0;
    endtask

    task automatic release_reset(input int waits);
        wait_cycles = waits;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Logs each completed transfer and flags requests that change or drop before ready.
    task automatic observe();
        if (mem_req) begin
            if (pend && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wd)) stable_err++;
            cur_cycles++;
            if (mem_ready) begin
                log_q.push_back('{mem_addr, mem_we, mem_wdata, cur_cycles});
                pend       = 1'b0;
                cur_cycles = 0;
            end else begin
                pend   = 1'b1;
                p_addr = mem_addr;
                p_we   = mem_we;
                p_wd   = mem_wdata;
            end
        end else if (pend) begin
            stable_err++;
            pend       = 1'b0;
            cur_cycles = 0;
        end
    endtask

    task automatic run_to_halt(input int max_cycles, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            #1;
            observe();
            if (halted) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic load_arith();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        mem[3] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
        mem[4] = 32'h0;
    endtask

    task automatic test_reset();
        hold_reset();
        load_arith();
        n_asserts++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", mem_req); end
        n_asserts++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
        n_asserts++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
        n_asserts++; if (cycle_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cycle_cnt: got %0d expected 0", cycle_cnt); end
        release_reset(0);
        #1;
        n_asserts++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL first_fetch: got req=%b we=%b addr=%h expected req=1 we=0 addr=00000000", mem_req, mem_we, mem_addr); end
        @(negedge clk);
        n_asserts++; if (pc !== 32'h4) begin n_fail++; $display("FAIL pc_after_fetch: got %h expected 00000004", pc); end
    endtask

    task automatic test_arith();
        bit to;
        hold_reset();
        load_arith();
        release_reset(0);
        run_to_halt(200, to);
        n_asserts++; if (to !== 1'b0) begin n_fail++; $display("FAIL arith_timeout: halted never rose"); end
        n_asserts++; if (u_dut.u_regfile.regs_q[2] !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL arith_r2: got %h expected fffffffd", u_dut.u_regfile.regs_q[2]); end
        n_asserts++; if (u_dut.u_regfile.regs_q[3] !== 32'd2) begin n_fail++; $display("FAIL arith_add_r3: got %h expected 00000002", u_dut.u_regfile.regs_q[3]); end
        n_asserts++; if (u_dut.u_regfile.regs_q[4] !== 32'd1) begin n_fail++; $display("FAIL arith_slt_r4: got %h expected 00000001", u_dut.u_regfile.regs_q[4]); end
        n_asserts++; if (pc !== 32'h14) begin n_fail++; $display("FAIL arith_halt_pc: got %h expected 00000014", pc); end
        n_asserts++; if (instret_cnt !== (PERF ? 32'd4 : 32'd0)) begin n_fail++; $display("FAIL arith_instret: got %0d expected %0d", instret_cnt, PERF ? 4 : 0); end
        n_asserts++; if (cycle_cnt !== (PERF ? 32'd18 : 32'd0)) begin n_fail++; $display("FAIL arith_cycles: got %0d expected %0d", cycle_cnt, PERF ? 18 : 0); end
    endtask

    task automatic test_logic();
        bit to;
        hold_reset();
        mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd12);
        mem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd10);
        mem[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h22);
        mem[3]  = enc_r(5'd1, 5'd2, 5'd4, 6'h24);
        mem[4]  = enc_r(5'd1, 5'd2, 5'd5, 6'h25);
        mem[5]  = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
        mem[6]  = 32'hFC000000;
        mem[7]  = enc_r(5'd1, 5'd2, 5'd6, 6'h2A);
        mem[8]  = enc_r(5'd2, 5'd1, 5'd7, 6'h22);
        mem[9]  = enc_r(5'd1, 5'd2, 5'd8, 6'h3F);
        mem[10] = 32'h0;
        release_reset(0);
        run_to_halt(300, to);
        n_asserts++; if (to !== 1'b0) begin n_fail++; $display("FAIL logic_timeout: halted never rose"); end
        n_asserts++; if (u_dut.u_regfile.regs_q[3] !== 32'd2) begin n_fail++; $display("FAIL logic_sub: got %h expected 00000002", u_dut.u_regfile.regs_q[3]); end
        n_asserts++; if (u_dut.u_regfile.regs_q[4] !== 32'd8) begin n_fail++; $display("FAIL logic_and: got %h expected 00000008", u_dut.u_regfile.regs_q[4]); end
        n_asserts++; if (u_dut.u_regfile.regs_q[5] !== 32'd14) begin n_fail++; $display("FAIL logic_or: got %h expected 0000000e", u_dut.u_regfile.regs_q[5]); end
        n_asserts++; if (u_dut.u_regfile.regs_q[0] !== 32'd0) begin n_fail++; $display("FAIL logic_r0: got %h expected 00000000", u_dut.u_regfile.regs_q[0]); end
        n_asserts++; if (u_dut.u_regfile.regs_q[6] !== 32'd0) begin n_fail++; $display("FAIL logic_slt_false: got %h expected 00000000", u_dut.u_regfile.regs_q[6]); end
        n_asserts++; if (u_dut.u_regfile.regs_q[7] !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL logic_sub_neg: got %h expected fffffffe", u_dut.u_regfile.regs_q[7]); end
        n_asserts++; if (u_dut.u_regfile.regs_q[8] !== 32'd0) begin n_fail++; $display("FAIL logic_bad_funct: got %h expected 00000000", u_dut.u_regfile.regs_q[8]); end
        n_asserts++; if (pc !== 32'h2C) begin n_fail++; $display("FAIL logic_halt_pc: got %h expected 0000002c", pc); end
        n_asserts++; if (instret_cnt !== (PERF ? 32'd10 : 32'd0)) begin n_fail++; $display("FAIL logic_instret: got %0d expected %0d", instret_cnt, PERF ? 10 : 0); end
    endtask

    task automatic test_mem_wait();
        bit to;
        hold_reset();
        mem[0]  = enc_j(26'h10);
        mem[16] = enc_i(6'h08, 5'd0, 5'd3, 16'd2);
        mem[17] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
        mem[18] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);
        mem[19] = 32'h0;
        release_reset(3);
        run_to_halt(400, to);
        n_asserts++; if (to !== 1'b0) begin n_fail++; $display("FAIL memw_timeout: halted never rose"); end
        n_asserts++; if (log_q.size() !== 7) begin n_fail++; $display("FAIL memw_xfers: got %0d expected 7", log_q.size()); end
        if (log_q.size() == 7) begin
            n_asserts++; if ({log_q[3].addr, log_q[3].we, log_q[3].wdata} !== {32'h8, 1'b1, 32'h2}) begin n_fail++; $display("FAIL memw_store: got addr=%h we=%b data=%h expected addr=00000008 we=1 data=00000002", log_q[3].addr, log_q[3].we, log_q[3].wdata); end
            n_asserts++; if (log_q[3].cycles !== 4) begin n_fail++; $display("FAIL memw_store_wait: got %0d cycles expected 4", log_q[3].cycles); end
            n_asserts++; if ({log_q[5].addr, log_q[5].we} !== {32'h8, 1'b0}) begin n_fail++; $display("FAIL memw_load: got addr=%h we=%b expected addr=00000008 we=0", log_q[5].addr, log_q[5].we); end
            n_asserts++; if (log_q[5].cycles !== 4) begin n_fail++; $display("FAIL memw_load_wait: got %0d cycles expected 4", log_q[5].cycles); end
        end
        n_asserts++; if (stable_err !== 0) begin n_fail++; $display("FAIL memw_stable: got %0d unstable request cycles expected 0", stable_err); end
        n_asserts++; if (mem[2] !== 32'd2) begin n_fail++; $display("FAIL memw_stored_word: got %h expected 00000002", mem[2]); end
        n_asserts++; if (u_dut.u_regfile.regs_q[5] !== 32'd2) begin n_fail++; $display("FAIL memw_lw_r5: got %h expected 00000002", u_dut.u_regfile.regs_q[5]); end
        n_asserts++; if (instret_cnt !== (PERF ? 32'd4 : 32'd0)) begin n_fail++; $display("FAIL memw_instret: got %0d expected %0d", instret_cnt, PERF ? 4 : 0); end
    endtask

    task automatic test_branch();
        bit to;
        hold_reset();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
        mem[1] = enc_j(26'h4);
        mem[4] = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
        mem[5] = enc_i(6'h08, 5'd0, 5'd6, 16'd1);
        mem[6] = enc_i(6'h08, 5'd0, 5'd6, 16'd2);
        mem[7] = enc_i(6'h05, 5'd1, 5'd1, 16'd5);
        mem[8] = 32'h0;
        release_reset(0);
        run_to_halt(200, to);
        n_asserts++; if (to !== 1'b0) begin n_fail++; $display("FAIL br_timeout: halted never rose"); end
        n_asserts++; if (log_q.size() !== 5) begin n_fail++; $display("FAIL br_fetches: got %0d expected 5", log_q.size()); end
        if (log_q.size() == 5) begin
            n_asserts++; if (log_q[3].addr !== 32'h1C) begin n_fail++; $display("FAIL br_beq_taken: got %h expected 0000001c", log_q[3].addr); end
            n_asserts++; if (log_q[4].addr !== 32'h20) begin n_fail++; $display("FAIL br_bne_not_taken: got %h expected 00000020", log_q[4].addr); end
        end
        n_asserts++; if (u_dut.u_regfile.regs_q[6] !== 32'd0) begin n_fail++; $display("FAIL br_skipped: got %h expected 00000000", u_dut.u_regfile.regs_q[6]); end
        n_asserts++; if (pc !== 32'h24) begin n_fail++; $display("FAIL br_halt_pc: got %h expected 00000024", pc); end
    endtask

    task automatic test_jump_halt();
        bit to;
        bit req_seen;
        hold_reset();
        mem[0]  = enc_j(26'h40);
        mem[64] = 32'h0;
        release_reset(0);
        run_to_halt(100, to);
        n_asserts++; if (to !== 1'b0) begin n_fail++; $display("FAIL jh_timeout: halted never rose"); end
        n_asserts++; if (log_q.size() !== 2) begin n_fail++; $display("FAIL jh_fetches: got %0d expected 2", log_q.size()); end
        if (log_q.size() == 2) begin
            n_asserts++; if (log_q[1].addr !== 32'h100) begin n_fail++; $display("FAIL jh_target: got %h expected 00000100", log_q[1].addr); end
        end
        n_asserts++; if (pc !== 32'h104) begin n_fail++; $display("FAIL jh_halt_pc: got %h expected 00000104", pc); end
        req_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_req || !halted) req_seen = 1'b1;
        end
        n_asserts++; if (req_seen !== 1'b0) begin n_fail++; $display("FAIL jh_sticky: got activity after halt expected none"); end
        n_asserts++; if (instret_cnt !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL jh_instret: got %0d expected %0d", instret_cnt, PERF ? 1 : 0); end
    endtask

    task automatic test_reset_mid_xfer();
        bit to;
        hold_reset();
        load_arith();
        release_reset(2);
        repeat (7) @(negedge clk);
        n_asserts++; if ({mem_req, mem_ready, mem_addr, pc} !== {1'b1, 1'b0, 32'h4, 32'h4}) begin n_fail++; $display("FAIL rmid_pending: got req=%b ready=%b addr=%h pc=%h expected 1 0 00000004 00000004", mem_req, mem_ready, mem_addr, pc); end
        n_asserts++; if (cycle_cnt !== (PERF ? 32'd7 : 32'd0)) begin n_fail++; $display("FAIL rmid_cycles_before: got %0d expected %0d", cycle_cnt, PERF ? 7 : 0); end
        #2;
        rst = 1'b0;
        #1;
        n_asserts++; if ({mem_req, mem_we, pc, halted} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin n_fail++; $display("FAIL rmid_drop: got req=%b we=%b pc=%h halted=%b expected 0 0 00000000 0", mem_req, mem_we, pc, halted); end
        n_asserts++; if ({cycle_cnt, instret_cnt} !== 64'h0) begin n_fail++; $display("FAIL rmid_counters: got %0d %0d expected 0 0", cycle_cnt, instret_cnt); end
        n_asserts++; if (u_dut.u_regfile.regs_q[1] !== 32'd0) begin n_fail++; $display("FAIL rmid_regs: got %h expected 00000000", u_dut.u_regfile.regs_q[1]); end
        hold_reset();
        load_arith();
        release_reset(0);
        run_to_halt(200, to);
        n_asserts++; if ({to, u_dut.u_regfile.regs_q[3]} !== {1'b0, 32'd2}) begin n_fail++; $display("FAIL rmid_rerun: got timeout=%b r3=%h expected 0 00000002", to, u_dut.u_regfile.regs_q[3]); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_mem_wait();
        test_branch();
        test_jump_halt();
        test_reset_mid_xfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
